line_window_buffer: RTL and testbench
=====================================

// Module: line_window_buffer
// PURPOSE
//  Parametrised single-line pixel buffer for the conv front-end. Stores up to LINE_WIDTH
//  fixed-point samples in a circular array and emits KERNEL-tap horizontal windows.
//  Has a ready/valid handshake on both sides, an occupancy count, and non-power-of-2 wrap.
//  Optional zero padding at the right edge of a line.
//  KERNEL instances stacked vertically feed the KxK MAC array.
// PARAMETERS
//  INTEGER_BITS      9    integer bits per sample
//  FIXED_POINT_BITS  4    fractional bits per sample; DATA_W = INTEGER_BITS+FIXED_POINT_BITS
//  LINE_WIDTH        512  samples per line = storage depth; any value >= KERNEL (not only 2^n)
//  KERNEL            3    taps per output window, 1..8
//  PAD_ZERO          1    1: zero the taps past the end of a line; 0: taps wrap into the next line
// PORTS
//  i_clk         in   1               sole clock, rising edge
//  i_rst         in   1               synchronous, active-low reset
//  i_data        in   DATA_W          sample to store
//  i_data_valid  in   1               write request
//  o_wr_ready    out  1               1 when count < LINE_WIDTH
//  i_rd_data     in   1               window read request
//  o_rd_ready    out  1               1 when a window is available (see BEHAVIOUR)
//  o_data        out  DATA_W*KERNEL   window; tap 0 (oldest) in the MSBs
//  o_data_valid  out  1               o_data is valid this cycle
//  o_count       out  $clog2(LINE_WIDTH+1)  stored, unconsumed samples
//  o_col         out  $clog2(LINE_WIDTH)    column of tap 0 of the next window
// BEHAVIOUR
//  Reset (i_rst==0 at posedge):
//   - wr_ptr, rd_ptr, count, col, o_data, o_data_valid all become 0.
//   - Array contents are not reset.
//  Write accepted = i_data_valid & o_wr_ready:
//   - mem[wr_ptr] <= i_data.
//   - wr_ptr wraps from LINE_WIDTH-1 to 0.
//   - A write while full is dropped silently; ptr and count are unchanged.
//  Read window availability:
//   - rem = LINE_WIDTH - col.
//   - need = (PAD_ZERO && rem < KERNEL) ? rem : KERNEL.
//   - o_rd_ready = (count >= need).
//  Read accepted = i_rd_data & o_rd_ready:
//   - Next cycle: o_data_valid=1, and tap k = mem[(rd_ptr+k) mod LINE_WIDTH] for k=0..KERNEL-1.
//   - If PAD_ZERO and k >= rem, tap k = 0 instead.
//   - Latency is exactly 1 cycle, fully pipelined: one window per cycle.
//  A read that is not accepted:
//   - o_data_valid=0 next cycle.
//   - o_data holds its last value.
//   - No error flag.
//  After an accepted read:
//   - rd_ptr advances 1 (mod LINE_WIDTH); count decrements 1.
//   - col advances 1, wrapping LINE_WIDTH-1 -> 0 (line boundary).
//  Simultaneous accepted write + read:
//   - count is unchanged.
//   - The write lands at wr_ptr. The read uses array contents before the edge, so there is no bypass.
//  Full: count==LINE_WIDTH, so o_wr_ready=0. Reads remain allowed; a read frees one slot next cycle.
//  Empty: count==0, so o_rd_ready=0 (the PAD_ZERO rem>=1 case still needs >= 1 sample).
//  Reset mid-stream: pointers and count clear in the same cycle; any pending o_data_valid drops to 0.
//  Widths: all pointer sums use explicit mod LINE_WIDTH (compare and subtract, never a bit truncation).
// STRUCTURE
//  - Shared package nn_fixed_pkg: INTEGER_BITS/FIXED_POINT_BITS defaults, DATA_W, clog2 helper.
//  - Sub-module line_window_mem: register array, 1 write port, KERNEL combinational read taps
//    with modulo address generation.
//  - Top level: pointers, count, col, handshake, padding mux, output register.
// TESTING
//  - Reset: hold i_rst=0 for 2 cycles, then release -> o_count=0, o_rd_ready=0, o_wr_ready=1, o_data_valid=0.
//  - LINE_WIDTH=512, K=3: write 1..5, then read 3 times -> windows {1,2,3},{2,3,4},{3,4,5},
//    each 1 cycle after its request; o_count=2.
//  - LINE_WIDTH=10, PAD_ZERO=1: stream 0..9 and read until col=8 -> {8,9,0}, then col=9 -> {9,0,0};
//    col returns to 0.
//  - LINE_WIDTH=10, PAD_ZERO=0: write 12 samples with reads interleaved -> window at col 9 = {9,10,11};
//    wr_ptr wrapped to 2.
//  - Full: write 10 samples with LINE_WIDTH=10 -> o_wr_ready=0 and the 11th write is dropped.
//    Then read+write in the same cycle -> o_count stays 9.
//  - Reset asserted the cycle after a read accept -> o_data_valid=0 and o_count=0 next cycle.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point sample format for the conv front-end, plus a width helper
// that never returns a zero-width result.
package nn_fixed_pkg;

  localparam int DEF_INTEGER_BITS     = 9;
  localparam int DEF_FIXED_POINT_BITS = 4;
  localparam int DEF_DATA_W           = DEF_INTEGER_BITS + DEF_FIXED_POINT_BITS;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/line_window_mem.sv
// Register-array line storage with one write port and KERNEL combinational
// read taps starting at rd_base, wrapping modulo DEPTH (any depth, not only 2^n).
module line_window_mem
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 512,
  parameter int KERNEL = 3,
  parameter int PTR_W  = clog2_min1(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     wr_en,
  input  logic [PTR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [PTR_W-1:0]         rd_base,
  output logic [DATA_W*KERNEL-1:0] taps
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // One extra bit holds base+k before the compare-and-subtract wrap; since
  // KERNEL <= DEPTH a single subtraction always lands back in range.
  for (genvar k = 0; k < KERNEL; k++) begin : g_tap
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] addr;
    assign sum  = {1'b0, rd_base} + (PTR_W+1)'(k);
    assign addr = (sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(sum - (PTR_W+1)'(DEPTH))
                                             : sum[PTR_W-1:0];
    assign taps[DATA_W*(KERNEL-k)-1 -: DATA_W] = mem[addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Single-line circular sample buffer emitting KERNEL-tap horizontal windows,
// with optional zero padding past the right edge of a line.
module line_window_buffer
  import nn_fixed_pkg::*;
#(
  parameter int INTEGER_BITS     = DEF_INTEGER_BITS,
  parameter int FIXED_POINT_BITS = DEF_FIXED_POINT_BITS,
  parameter int LINE_WIDTH       = 512,
  parameter int KERNEL           = 3,
  parameter int PAD_ZERO         = 1,
  localparam int DATA_W          = INTEGER_BITS + FIXED_POINT_BITS,
  localparam int CNT_W           = clog2_min1(LINE_WIDTH + 1),
  localparam int COL_W           = clog2_min1(LINE_WIDTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_data_valid,
  output logic                     o_wr_ready,
  input  logic                     i_rd_data,
  output logic                     o_rd_ready,
  output logic [DATA_W*KERNEL-1:0] o_data,
  output logic                     o_data_valid,
  output logic [CNT_W-1:0]         o_count,
  output logic [COL_W-1:0]         o_col
);

  // Handshake: a write is taken on a rising edge where i_data_valid && o_wr_ready,
  // a read where i_rd_data && o_rd_ready; both ready flags depend only on state,
  // never on the request inputs, and an unaccepted request has no side effect.

  logic [COL_W-1:0]         wr_ptr;
  logic [COL_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         rem;
  logic [CNT_W-1:0]         need;
  logic                     wr_fire;
  logic                     rd_fire;
  logic [DATA_W*KERNEL-1:0] taps;
  logic [DATA_W*KERNEL-1:0] window;

  function automatic logic [COL_W-1:0] ptr_inc(input logic [COL_W-1:0] p);
    return (p == COL_W'(LINE_WIDTH - 1)) ? '0 : p + COL_W'(1);
  endfunction

  // rd_ptr and the column of tap 0 start together and wrap together, so one
  // register serves as both.
  assign rem  = CNT_W'(LINE_WIDTH) - CNT_W'(rd_ptr);
  assign need = (PAD_ZERO != 0 && rem < CNT_W'(KERNEL)) ? rem : CNT_W'(KERNEL);

  assign o_wr_ready = (count < CNT_W'(LINE_WIDTH));
  assign o_rd_ready = (count >= need);
  assign wr_fire    = i_data_valid && o_wr_ready;
  assign rd_fire    = i_rd_data && o_rd_ready;
  assign o_count    = count;
  assign o_col      = rd_ptr;

  line_window_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_WIDTH),
    .KERNEL (KERNEL),
    .PTR_W  (COL_W)
  ) u_mem (
    .i_clk   (i_clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_base (rd_ptr),
    .taps    (taps)
  );

  for (genvar k = 0; k < KERNEL; k++) begin : g_pad
    assign window[DATA_W*(KERNEL-k)-1 -: DATA_W] =
      (PAD_ZERO != 0 && CNT_W'(k) >= rem) ? '0 : taps[DATA_W*(KERNEL-k)-1 -: DATA_W];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= rd_fire;
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
        o_data <= window;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: three instances (512/pad, 10/pad, 10/wrap) driven
// in lockstep and compared against a stream-position reference model.
module tb_line_window_buffer;

  localparam int DW   = 13;
  localparam int K    = 3;
  localparam int WW   = DW * K;
  localparam int HIST = 4096;

  // clock / reset block
  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_data_valid;
  logic          i_rd_data;
  logic [DW-1:0] i_data;

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got no summary, required summary");
    $fatal(1);
  end

  logic          wr0, rr0, dv0, wr1, rr1, dv1, wr2, rr2, dv2;
  logic [WW-1:0] dat0, dat1, dat2;
  logic [9:0]    cnt0;
  logic [8:0]    col0;
  logic [3:0]    cnt1, col1, cnt2, col2;

  line_window_buffer #(.LINE_WIDTH(512), .KERNEL(K), .PAD_ZERO(1)) u_dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_wr_ready(wr0), .i_rd_data(i_rd_data), .o_rd_ready(rr0), .o_data(dat0),
    .o_data_valid(dv0), .o_count(cnt0), .o_col(col0));

  line_window_buffer #(.LINE_WIDTH(10), .KERNEL(K), .PAD_ZERO(1)) u_dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_wr_ready(wr1), .i_rd_data(i_rd_data), .o_rd_ready(rr1), .o_data(dat1),
    .o_data_valid(dv1), .o_count(cnt1), .o_col(col1));

  line_window_buffer #(.LINE_WIDTH(10), .KERNEL(K), .PAD_ZERO(0)) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_wr_ready(wr2), .i_rd_data(i_rd_data), .o_rd_ready(rr2), .o_data(dat2),
    .o_data_valid(dv2), .o_count(cnt2), .o_col(col2));

  logic          wr_rdy [3];
  logic          rd_rdy [3];
  logic          dv     [3];
  logic [WW-1:0] dat    [3];
  logic [9:0]    cnt    [3];
  logic [8:0]    col    [3];

  always_comb begin
    wr_rdy[0] = wr0;  wr_rdy[1] = wr1;  wr_rdy[2] = wr2;
    rd_rdy[0] = rr0;  rd_rdy[1] = rr1;  rd_rdy[2] = rr2;
    dv[0]     = dv0;  dv[1]     = dv1;  dv[2]     = dv2;
    dat[0]    = dat0; dat[1]    = dat1; dat[2]    = dat2;
    cnt[0]    = cnt0; cnt[1]    = 10'(cnt1); cnt[2] = 10'(cnt2);
    col[0]    = col0; col[1]    = 9'(col1);  col[2] = 9'(col2);
  end

  // reference model: every sample ever written, indexed by stream position
  logic [DW-1:0] hist [3][HIST];
  int            nw [3];
  int            nr [3];
  logic          exp_dv [3];
  logic [WW-1:0] hold [3];
  logic [WW-1:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int lw_of(input int i);
    return (i == 0) ? 512 : 10;
  endfunction

  function automatic int pad_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic int m_count(input int i);
    return nw[i] - nr[i];
  endfunction

  function automatic int m_col(input int i);
    return nr[i] % lw_of(i);
  endfunction

  function automatic int m_need(input int i);
    int rem;
    rem = lw_of(i) - m_col(i);
    return (pad_of(i) != 0 && rem < K) ? rem : K;
  endfunction

  function automatic logic [WW-1:0] win3(input int a, input int b, input int c);
    return {DW'(a), DW'(b), DW'(c)};
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", name, i, $time, act, exp);
  endtask

  task automatic model_edge(input logic rst_n, input logic wv, input logic [DW-1:0] wd,
                            input logic rv);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        nw[i] = 0; nr[i] = 0; exp_dv[i] = 1'b0; hold[i] = '0;
      end else begin
        logic          wa, ra;
        logic [WW-1:0] win;
        int            rem;
        wa = wv && (m_count(i) < lw_of(i));
        ra = rv && (m_count(i) >= m_need(i));
        exp_dv[i] = ra;
        if (ra) begin
          win = '0;
          rem = lw_of(i) - m_col(i);
          for (int k = 0; k < K; k++)
            if (!(pad_of(i) != 0 && k >= rem))
              win[WW-1-DW*k -: DW] = hist[i][(nr[i] + k) % HIST];
          exp_q.push_back(win);
          nr[i]++;
        end
        if (wa) begin
          hist[i][nw[i] % HIST] = wd;
          nw[i]++;
        end
      end
    end
  endtask

  task automatic check_pre(input int i);
    chk("wr_ready", i, 64'(wr_rdy[i]), 64'(m_count(i) < lw_of(i)));
    chk("rd_ready", i, 64'(rd_rdy[i]), 64'(m_count(i) >= m_need(i)));
    chk("count",    i, 64'(cnt[i]),    64'(m_count(i)));
    chk("col",      i, 64'(col[i]),    64'(m_col(i)));
  endtask

  task automatic check_post(input int i);
    chk("valid", i, 64'(dv[i]), 64'(exp_dv[i]));
    if (exp_dv[i]) begin
      hold[i] = exp_q.pop_front();
      chk("window", i, 64'(dat[i]), 64'(hold[i]));
    end else begin
      chk("hold", i, 64'(dat[i]), 64'(hold[i]));
    end
  endtask

  // driver: one clock cycle, entered and left at the falling edge
  task automatic step(input logic rst_n, input logic wv, input logic [DW-1:0] wd,
                      input logic rv);
    i_rst = rst_n; i_data_valid = wv; i_data = wd; i_rd_data = rv;
    #1;
    for (int i = 0; i < 3; i++) check_pre(i);
    model_edge(rst_n, wv, wd, rv);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check_post(i);
    @(negedge clk);
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          edv;
    logic [WW-1:0] ewin;
    int            ecnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input int d, input logic r, input logic edv,
                              input logic [WW-1:0] ewin, input int ecnt);
    vec_t t;
    t.v = v; t.d = DW'(d); t.r = r; t.edv = edv; t.ewin = ewin; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tab [9];

  initial begin
    for (int n = 0; n < 5; n++) tab[n] = mk(1'b1, n + 1, 1'b0, 1'b0, '0, n + 1);
    tab[5] = mk(1'b0, 0, 1'b1, 1'b1, win3(1, 2, 3), 4);
    tab[6] = mk(1'b0, 0, 1'b1, 1'b1, win3(2, 3, 4), 3);
    tab[7] = mk(1'b0, 0, 1'b1, 1'b1, win3(3, 4, 5), 2);
    tab[8] = mk(1'b0, 0, 1'b0, 1'b0, win3(3, 4, 5), 2);

    // reset held for two cycles, no checks while state is still unknown
    i_rst = 1'b0; i_data_valid = 1'b0; i_data = '0; i_rd_data = 1'b0;
    repeat (2) @(posedge clk);
    model_edge(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_count",    i, 64'(cnt[i]),    64'd0);
      chk("rst_rd_ready", i, 64'(rd_rdy[i]), 64'd0);
      chk("rst_wr_ready", i, 64'(wr_rdy[i]), 64'd1);
      chk("rst_valid",    i, 64'(dv[i]),     64'd0);
      chk("rst_data",     i, 64'(dat[i]),    64'd0);
    end

    // write 1..5 then three reads on the deep line
    for (int j = 0; j < 9; j++) begin
      step(1'b1, tab[j].v, tab[j].d, tab[j].r);
      chk("tab_valid", 0, 64'(dv[0]),  64'(tab[j].edv));
      chk("tab_win",   0, 64'(dat[0]), 64'(tab[j].ewin));
      chk("tab_count", 0, 64'(cnt[0]), 64'(tab[j].ecnt));
    end

    // right-edge zero padding on a 10-wide line
    step(1'b0, 1'b0, '0, 1'b0);
    for (int s = 0; s < 10; s++) step(1'b1, 1'b1, DW'(s), 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (c == 7) chk("pad_col8", 1, 64'(col[1]), 64'd8);
      if (c == 8) chk("pad_win8", 1, 64'(dat[1]), 64'(win3(8, 9, 0)));
      if (c == 9) chk("pad_win9", 1, 64'(dat[1]), 64'(win3(9, 0, 0)));
    end
    chk("pad_col_wrap", 1, 64'(col[1]), 64'd0);
    chk("pad_empty",    1, 64'(cnt[1]), 64'd0);

    // no padding: taps at the end of a line wrap into the next one
    step(1'b0, 1'b0, '0, 1'b0);
    for (int s = 0; s < 12; s++) step(1'b1, 1'b1, DW'(s), (s >= 3));
    step(1'b1, 1'b0, '0, 1'b1);
    chk("wrap_win9",  2, 64'(dat[2]), 64'(win3(9, 10, 11)));
    chk("wrap_col",   2, 64'(col[2]), 64'd0);
    chk("wrap_count", 2, 64'(cnt[2]), 64'd2);

    // full line: extra write dropped, read frees a slot, read+write holds count
    step(1'b0, 1'b0, '0, 1'b0);
    for (int s = 0; s < 10; s++) step(1'b1, 1'b1, DW'(100 + s), 1'b0);
    chk("full_wr_ready", 1, 64'(wr_rdy[1]), 64'd0);
    chk("full_count",    1, 64'(cnt[1]),    64'd10);
    step(1'b1, 1'b1, DW'(110), 1'b0);
    chk("full_drop",     1, 64'(cnt[1]),    64'd10);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("full_rd_count", 1, 64'(cnt[1]),    64'd9);
    chk("full_rd_win",   1, 64'(dat[1]),    64'(win3(100, 101, 102)));
    step(1'b1, 1'b1, DW'(111), 1'b1);
    chk("full_rw_count", 1, 64'(cnt[1]),    64'd9);
    chk("full_rw_win",   1, 64'(dat[1]),    64'(win3(101, 102, 103)));
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, '0, 1'b1);
    chk("full_tail_win",   1, 64'(dat[1]), 64'(win3(109, 0, 0)));
    chk("full_tail_count", 1, 64'(cnt[1]), 64'd1);

    // reset the cycle after an accepted read
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, DW'(7), 1'b0);
    step(1'b1, 1'b1, DW'(8), 1'b0);
    step(1'b1, 1'b1, DW'(9), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("mid_valid", 0, 64'(dv[0]),  64'd1);
    chk("mid_win",   0, 64'(dat[0]), 64'(win3(7, 8, 9)));
    step(1'b0, 1'b0, '0, 1'b1);
    chk("mid_rst_valid", 0, 64'(dv[0]),  64'd0);
    chk("mid_rst_count", 0, 64'(cnt[0]), 64'd0);
    chk("mid_rst_data",  0, 64'(dat[0]), 64'd0);

    // random traffic: write-heavy half to reach full, read-heavy half to drain
    for (int n = 0; n < 3000; n++) begin
      logic wv, rv, rn;
      wv = ($urandom_range(0, 99) < ((n < 1500) ? 80 : 35));
      rv = ($urandom_range(0, 99) < ((n < 1500) ? 35 : 80));
      rn = ($urandom_range(0, 999) != 0);
      step(rn, wv, DW'($urandom_range(0, 8191)), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
